// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a data port.
// One access is in flight at a time. Data has priority, but fetch waits at most STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err_spurious
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    // The owner and the we bit are kept together as one transaction kind.
    typedef enum logic [1:0] {TXN_FETCH, TXN_LOAD, TXN_STORE} txn_t;

    state_t        state_reg, state_next;
    txn_t          txn_reg, txn_next;
    logic [CW-1:0] starve_reg, starve_next;
    logic [31:0]   i_rdata_reg, d_rdata_reg;
    logic          err_reg;
    logic          fetch_wins;
    logic          unused_addr_bits;

    // The memory is word addressed, so the byte offset never reaches it.
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    assign fetch_wins = i_req && (!d_req || starve_reg == LIMIT);

    always_comb begin
        state_next = state_reg;
        txn_next   = txn_reg;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        case (state_reg)
            IDLE: begin
                // Grants are combinational from the request, so they are masked while reset is held.
                if (rst_n) begin
                    if (fetch_wins) begin
                        i_gnt      = 1'b1;
                        txn_next   = TXN_FETCH;
                        state_next = BUSY;
                    end else if (d_req) begin
                        d_gnt      = 1'b1;
                        txn_next   = d_we ? TXN_STORE : TXN_LOAD;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem_rvalid) state_next = RESP;
            end
            RESP: begin
                i_rvalid   = (txn_reg == TXN_FETCH);
                d_rvalid   = (txn_reg != TXN_FETCH);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        starve_next = starve_reg;
        if (!i_req || i_gnt)
            starve_next = '0;
        else if (d_gnt && starve_reg != LIMIT)
            starve_next = starve_reg + CW'(1);
    end

    always_comb begin
        mem_req   = i_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (i_gnt) begin
            mem_be   = 4'hF;
            mem_addr = {i_addr[31:2], 2'b00};
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_we ? d_be : 4'hF;
            mem_addr  = {d_addr[31:2], 2'b00};
            mem_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            txn_reg    <= TXN_FETCH;
            starve_reg <= '0;
        end else begin
            state_reg  <= state_next;
            txn_reg    <= txn_next;
            starve_reg <= starve_next;
        end
    end

    // Responses outside BUSY never reach the read-data registers and only raise the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_rdata_reg <= 32'h0;
            d_rdata_reg <= 32'h0;
            err_reg     <= 1'b0;
        end else begin
            if (state_reg == BUSY && mem_rvalid) begin
                if (txn_reg == TXN_FETCH) i_rdata_reg <= mem_rdata;
                else                      d_rdata_reg <= mem_rdata;
            end
            if (mem_rvalid && state_reg != BUSY) err_reg <= 1'b1;
        end
    end

    assign i_rdata      = i_rdata_reg;
    assign d_rdata      = d_rdata_reg;
    assign err_spurious = err_reg;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while an instruction request is pending.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  fetch request; held with i_addr until i_gnt.
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_gnt  output  1  fetch request accepted this cycle.
REQ-007 i_rvalid  output  1  one-cycle pulse, i_rdata valid.
REQ-008 i_rdata  output  32  fetch read data.
REQ-009 d_req  input  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_be  input  4  byte enables for stores; ignored for loads.
REQ-012 d_addr  input  32  data byte address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  one-cycle pulse: load data valid or store acknowledged.
REQ-016 d_rdata  output  32  load data.
REQ-017 mem_req  output  1  single-port memory request.
REQ-018 mem_we  output  1  memory write enable.
REQ-019 mem_be  output  4  memory byte enables.
REQ-020 mem_addr  output  32  word-aligned memory address.
REQ-021 mem_wdata  output  32  memory write data.
REQ-022 mem_rvalid  input  1  memory response, one cycle, at least 1 cycle after mem_req.
REQ-023 mem_rdata  input  32  memory read data, valid with mem_rvalid.
REQ-024 err_spurious  output  1  sticky flag: mem_rvalid received outside BUSY.

Function
REQ-025 The FSM SHALL have states IDLE, BUSY and RESP, with exactly one outstanding memory transaction.
REQ-026 Grants SHALL be issued only in IDLE, combinationally, in the same cycle as the request is seen; at most one of i_gnt/d_gnt is high.
REQ-027 Priority: data over fetch, except when starve_cnt == STARVE_LIMIT and i_req is high, in which case fetch wins.
REQ-028 starve_cnt SHALL increment on each d_gnt while i_req is high, saturate at STARVE_LIMIT, and clear on i_gnt or on any cycle with i_req low.
REQ-029 mem_req SHALL equal (i_gnt | d_gnt); mem_addr = {addr[31:2],2'b00} of the winner.
REQ-030 Fetch grant: mem_we=0, mem_be=4'hF, mem_wdata=0. Data grant: mem_we=d_we, mem_be = d_we ? d_be : 4'hF, mem_wdata=d_wdata.
REQ-031 Grant SHALL move IDLE->BUSY and register owner (I or D) and the request's we bit.
REQ-032 BUSY SHALL hold until mem_rvalid, then capture mem_rdata into the owner's rdata register and move to RESP.
REQ-033 RESP SHALL assert the owner's rvalid for exactly one cycle, then move to IDLE; the non-owner's rvalid stays 0.
REQ-034 Latency: grant at cycle T, mem_rvalid at T+k (k>=1) -> owner rvalid at T+k+1; earliest next grant at T+k+2.
REQ-035 Store completion SHALL pulse d_rvalid; d_rdata SHALL then hold the captured mem_rdata (don't-care to requester).
REQ-036 i_rdata/d_rdata SHALL hold their last captured value until the next response to that requester.
REQ-037 mem_rvalid in IDLE or RESP SHALL be ignored for data routing and SHALL set err_spurious, which stays set until reset.
REQ-038 Requests deasserted before grant SHALL be dropped without side effects; requests arriving in BUSY/RESP wait.

Reset
REQ-039 On rst_n low, immediately: state=IDLE, starve_cnt=0, owner=I, i_rdata=d_rdata=0, err_spurious=0, all rvalid/gnt/mem_req outputs 0.
REQ-040 Reset mid-transaction SHALL discard the outstanding access without any rvalid; a late mem_rvalid after reset release sets err_spurious.

Verification
REQ-041 Fetch only: i_req, i_addr=0x103, mem_rvalid 2 cycles after grant, rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=F, i_rvalid 1 cycle later with i_rdata=0xDEADBEEF.
REQ-042 Store: d_we=1, d_be=4'b0011, d_addr=0x40, d_wdata=0x1234 -> mem_we=1, mem_be=0011, mem_addr=0x40; d_rvalid one cycle after mem_rvalid; i_rvalid stays 0.
REQ-043 Simultaneous i_req and d_req with STARVE_LIMIT=4, 1-cycle memory -> first 4 grants to data, 5th to fetch, counter clears, then data again.
REQ-044 Back-to-back: mem_rvalid at T+1 -> rvalid at T+2, next grant no earlier than T+3.
REQ-045 Assert rst_n low in BUSY, release, then pulse mem_rvalid -> no rvalid pulse, err_spurious=1, FSM in IDLE and grants next request.
